// File: rtl/rom_load_dispatch_pkg.sv
// rom_load_dispatch_pkg
// Shared types and constants for the ROM download path.
//   region_storage_t : storage arbiter a load region is written through
//   region_t         : base address + storage of one load region
//   LOAD_REGIONS     : region table indexed by the download tag
//   game_t / board_cfg_t : board configuration record carried in the stream
//   load_state_t     : dispatcher FSM state constants
package rom_load_dispatch_pkg;

  localparam int unsigned NUM_LOAD_REGIONS = 8;
  localparam logic [7:0]  LOAD_TAG_CFG     = 8'hF0;
  localparam logic [7:0]  LOAD_TAG_END     = 8'hFF;

  typedef enum logic [3:0] {
    STORAGE_SDR   = 4'd0,
    STORAGE_DDR   = 4'd1,
    STORAGE_BLOCK = 4'd2
  } region_storage_t;

  typedef struct packed {
    logic [31:0]     base_addr;
    region_storage_t storage;
  } region_t;

  localparam logic [31:0] CPU_ROM_SDR_BASE     = 32'h0000_0000;
  localparam logic [31:0] SCN_DATA_SDR_BASE    = 32'h0090_0000;
  localparam logic [31:0] OBJ_DATA_DDR_BASE    = 32'h3000_0000;
  localparam logic [31:0] SOUND_ROM_BLOCK_BASE = 32'h0010_0000;
  localparam logic [31:0] ADPCMA_DDR_BASE      = 32'h3080_0000;
  localparam logic [31:0] ADPCMB_DDR_BASE      = 32'h30C0_0000;
  localparam logic [31:0] PROM_BLOCK_BASE      = 32'h0020_0000;
  // Sits at the top of the address space; a long payload wraps to 0.
  localparam logic [31:0] EXTRA_SDR_BASE       = 32'hFFFF_FFFC;

  localparam region_t LOAD_REGIONS [NUM_LOAD_REGIONS] = '{
    '{base_addr: CPU_ROM_SDR_BASE,     storage: STORAGE_SDR},
    '{base_addr: SCN_DATA_SDR_BASE,    storage: STORAGE_SDR},
    '{base_addr: OBJ_DATA_DDR_BASE,    storage: STORAGE_DDR},
    '{base_addr: SOUND_ROM_BLOCK_BASE, storage: STORAGE_BLOCK},
    '{base_addr: ADPCMA_DDR_BASE,      storage: STORAGE_DDR},
    '{base_addr: ADPCMB_DDR_BASE,      storage: STORAGE_DDR},
    '{base_addr: PROM_BLOCK_BASE,      storage: STORAGE_BLOCK},
    '{base_addr: EXTRA_SDR_BASE,       storage: STORAGE_SDR}
  };

  typedef enum logic [7:0] {
    GAME_NONE     = 8'h00,
    GAME_FINALB   = 8'h01,
    GAME_DONDOKOD = 8'h02,
    GAME_THUNDFOX = 8'h03,
    GAME_MEGABLST = 8'h04
  } game_t;

  typedef struct packed {
    game_t      game;
    logic [7:0] unused;
  } board_cfg_t;

  typedef logic [3:0] load_state_t;

  localparam load_state_t LOAD_HEADER  = 4'd0;
  localparam load_state_t LOAD_LEN     = 4'd1;
  localparam load_state_t LOAD_DATA_LO = 4'd2;
  localparam load_state_t LOAD_DATA_HI = 4'd3;
  localparam load_state_t LOAD_WRITE   = 4'd4;
  localparam load_state_t LOAD_CFG0    = 4'd5;
  localparam load_state_t LOAD_CFG1    = 4'd6;
  localparam load_state_t LOAD_DONE    = 4'd7;
  localparam load_state_t LOAD_ERROR   = 4'd8;

endpackage

// File: rtl/rom_load_dispatch_word_packer.sv
// rom_word_packer
// Packs payload bytes into 16-bit little-lane words and owns the write
// request handshake toward the storage arbiters.
//   clk, reset        : clock, synchronous active-high reset
//   byte_valid        : a payload byte is accepted this cycle
//   byte_hi           : accepted byte belongs in the high lane
//   flush             : accepted byte completes the word (issue request)
//   byte_data         : the payload byte
//   addr_in/storage_in: target of the word being completed
//   wr_*              : write request to storage, held until wr_ready
//   word_done         : request accepted this cycle (wr_valid & wr_ready)
module rom_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic        byte_hi,
  input  logic        flush,
  input  logic [7:0]  byte_data,
  input  logic [31:0] addr_in,
  input  logic [3:0]  storage_in,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_storage,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_be,
  output logic        word_done
);

  logic [7:0] lo_lane;

  assign word_done = wr_valid & wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_lane    <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_storage <= '0;
      wr_data    <= '0;
      wr_be      <= '0;
    end else begin
      // Request fields stay untouched after acceptance; only valid drops.
      if (word_done) begin
        wr_valid <= 1'b0;
      end
      if (byte_valid) begin
        if (!byte_hi) begin
          lo_lane <= byte_data;
        end
        if (flush) begin
          wr_valid   <= 1'b1;
          wr_addr    <= addr_in;
          wr_storage <= storage_in;
          // A word closed on a low-lane byte is the odd tail of a region.
          wr_data    <= byte_hi ? {byte_data, lo_lane} : {8'h00, byte_data};
          wr_be      <= byte_hi ? 2'b11 : 2'b01;
        end
      end
    end
  end

endmodule

// File: rtl/rom_load_dispatch.sv
// rom_load_dispatch
// Decodes the HPS ROM-download byte stream: region headers with 32-bit
// big-endian lengths, board-config records and the end marker. Payload goes
// to rom_word_packer, which issues 16-bit writes to the storage arbiters.
//   clk, reset         : clock, synchronous active-high reset
//   in_valid/in_ready/in_data : download byte stream
//   wr_*               : word write request toward SDR/DDR/BRAM muxes
//   board_cfg(_valid)  : latched board configuration record
//   busy, done, error  : status (done/error sticky until reset)
//
// state        | meaning
// HEADER       | waiting for a tag byte
// LEN          | collecting 4 length bytes, MSB first
// DATA_LO      | next payload byte goes to the low lane
// DATA_HI      | next payload byte goes to the high lane
// WRITE        | word request outstanding, stream stalled
// CFG0 / CFG1  | board_cfg high byte / low byte
// DONE         | end tag seen, stream drained
// ERROR        | bad tag seen, stream drained
module rom_load_dispatch
  import rom_load_dispatch_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = NUM_LOAD_REGIONS,
  parameter logic [7:0]  CFG_TAG     = LOAD_TAG_CFG,
  parameter logic [7:0]  END_TAG     = LOAD_TAG_END
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_storage,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_be,
  output logic [15:0] board_cfg,
  output logic        board_cfg_valid,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] REGION_TAG_LIMIT = NUM_REGIONS[7:0];

  load_state_t state;
  logic [1:0]  len_cnt;
  logic [23:0] len_shift;
  logic [31:0] remaining;
  logic [31:0] offset;
  logic [2:0]  region;
  region_t     region_entry;
  logic [31:0] len_full;
  logic        accept;
  logic        word_done;
  logic        byte_valid;
  logic        byte_hi;
  logic        flush;

  assign region_entry = LOAD_REGIONS[region];
  assign len_full     = {len_shift, in_data};

  // Held low while in reset so no byte is taken on the reset cycle.
  assign in_ready = ~reset & (state != LOAD_WRITE);
  assign accept   = in_valid & in_ready;

  assign busy  = (state != LOAD_HEADER) && (state != LOAD_DONE) && (state != LOAD_ERROR);
  assign done  = (state == LOAD_DONE);
  assign error = (state == LOAD_ERROR);

  assign byte_valid = accept && ((state == LOAD_DATA_LO) || (state == LOAD_DATA_HI));
  assign byte_hi    = (state == LOAD_DATA_HI);
  assign flush      = byte_hi || (remaining == 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= LOAD_HEADER;
      len_cnt         <= '0;
      len_shift       <= '0;
      remaining       <= '0;
      offset          <= '0;
      region          <= '0;
      board_cfg       <= '0;
      board_cfg_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_HEADER: begin
          if (accept) begin
            if (in_data < REGION_TAG_LIMIT) begin
              region  <= in_data[2:0];
              offset  <= '0;
              len_cnt <= '0;
              state   <= LOAD_LEN;
            end else if (in_data == CFG_TAG) begin
              state <= LOAD_CFG0;
            end else if (in_data == END_TAG) begin
              state <= LOAD_DONE;
            end else begin
              state <= LOAD_ERROR;
            end
          end
        end
        LOAD_LEN: begin
          if (accept) begin
            len_shift <= len_full[23:0];
            len_cnt   <= len_cnt + 2'd1;
            if (len_cnt == 2'd3) begin
              if (len_full == 32'd0) begin
                state <= LOAD_HEADER;
              end else begin
                remaining <= len_full;
                state     <= LOAD_DATA_LO;
              end
            end
          end
        end
        LOAD_DATA_LO: begin
          if (accept) begin
            remaining <= remaining - 32'd1;
            state     <= (remaining == 32'd1) ? LOAD_WRITE : LOAD_DATA_HI;
          end
        end
        LOAD_DATA_HI: begin
          if (accept) begin
            remaining <= remaining - 32'd1;
            state     <= LOAD_WRITE;
          end
        end
        LOAD_WRITE: begin
          if (word_done) begin
            offset <= offset + 32'd2;
            state  <= (remaining != 32'd0) ? LOAD_DATA_LO : LOAD_HEADER;
          end
        end
        LOAD_CFG0: begin
          if (accept) begin
            board_cfg[15:8] <= in_data;
            state           <= LOAD_CFG1;
          end
        end
        LOAD_CFG1: begin
          if (accept) begin
            board_cfg[7:0]  <= in_data;
            board_cfg_valid <= 1'b1;
            state           <= LOAD_HEADER;
          end
        end
        LOAD_DONE:  state <= LOAD_DONE;
        LOAD_ERROR: state <= LOAD_ERROR;
        default:    state <= LOAD_ERROR;
      endcase
    end
  end

  rom_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_hi    (byte_hi),
    .flush      (flush),
    .byte_data  (in_data),
    .addr_in    (region_entry.base_addr + offset),
    .storage_in (region_entry.storage),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_storage (wr_storage),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .word_done  (word_done)
  );

endmodule

// File: tb/tb_rom_load_dispatch.sv
// Testbench for rom_load_dispatch: directed vector table, hand-written
// stall / reset-mid-write sequences and randomized streams against a
// stream-level reference model.
module tb_rom_load_dispatch;
  import rom_load_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [3:0]  wr_storage;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [15:0] board_cfg;
  logic        board_cfg_valid;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  rom_load_dispatch dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_storage      (wr_storage),
    .wr_data         (wr_data),
    .wr_be           (wr_be),
    .board_cfg       (board_cfg),
    .board_cfg_valid (board_cfg_valid),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  storage;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_rec_t;

  typedef struct packed {
    logic [127:0] stream;   // stream-order bytes, left-justified
    logic [4:0]   n;
    logic [1:0]   nwr;
    wr_rec_t      w0;
    wr_rec_t      w1;
    logic         exp_done;
    logic         exp_err;
    logic         exp_cfgv;
    logic [15:0]  exp_cfg;
  } vec_t;

  int checks = 0;
  int errors = 0;

  wr_rec_t    obs[$];
  wr_rec_t    exp_q[$];
  logic [7:0] stim[$];
  bit         rand_ready = 1'b0;
  logic       m_done, m_err, m_cfgv;
  logic [15:0] m_cfg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, expv);
    end
  endtask

  function automatic wr_rec_t mkw(input logic [31:0] a, input logic [3:0] s,
                                  input logic [15:0] d, input logic [1:0] b);
    wr_rec_t r;
    r.addr = a; r.storage = s; r.data = d; r.be = b;
    return r;
  endfunction

  function automatic logic [127:0] lj(input logic [127:0] v, input int n);
    return v << (128 - 8 * n);
  endfunction

  // Stream-level reference: walks the record format and lists the words
  // each region must produce. Generated streams are never truncated.
  function automatic void run_model();
    int i, n, len;
    logic [7:0]  tag, lo, hi;
    logic [1:0]  be;
    logic [31:0] off;
    region_t     rg;
    exp_q.delete();
    m_done = 0; m_err = 0; m_cfgv = 0; m_cfg = '0;
    i = 0;
    n = stim.size();
    while (i < n) begin
      tag = stim[i];
      i++;
      if (tag < 8'd8) begin
        len = int'({stim[i], stim[i+1], stim[i+2], stim[i+3]});
        i += 4;
        rg = LOAD_REGIONS[tag[2:0]];
        off = 0;
        for (int k = 0; k < len; k += 2) begin
          lo = stim[i+k];
          if (k + 1 < len) begin hi = stim[i+k+1]; be = 2'b11; end
          else begin hi = 8'h00; be = 2'b01; end
          exp_q.push_back(mkw(rg.base_addr + off, rg.storage, {hi, lo}, be));
          off += 2;
        end
        i += len;
      end else if (tag == 8'hF0) begin
        m_cfg = {stim[i], stim[i+1]};
        m_cfgv = 1;
        i += 2;
      end else if (tag == 8'hFF) begin
        m_done = 1;
        break;
      end else begin
        m_err = 1;
        break;
      end
    end
  endfunction

  // Monitor: records accepted writes, checks request hold while stalled
  // and that no byte is accepted while a request is pending.
  logic        stall_prev = 1'b0;
  logic [54:0] prev_req;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          chk("stall_hold", {wr_valid, wr_addr, wr_storage, wr_data, wr_be}, {1'b1, prev_req[53:0]});
        if (wr_valid) chk("in_ready_in_write", in_ready, 0);
        if (wr_valid && wr_ready) obs.push_back({wr_addr, wr_storage, wr_data, wr_be});
        stall_prev = wr_valid && !wr_ready;
        prev_req = {1'b1, wr_addr, wr_storage, wr_data, wr_be};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) wr_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic do_reset(input bit check_vals);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    if (check_vals) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr", {wr_valid, wr_addr, wr_data, wr_be, wr_storage}, 0);
      chk("rst_cfg", {board_cfg, board_cfg_valid}, 0);
      chk("rst_status", {busy, done, error}, 0);
    end
    reset = 1'b0;
    if (check_vals) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    bit ok = 0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL byte_timeout: actual in_ready=0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy && !wr_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: actual busy=%0d required 0", busy);
    end
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_write_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk({tag, "_write"}, obs[i], exp_q[i]);
  endtask

  vec_t vecs[6];

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; wr_ready = 1'b0;

    vecs[0] = '{lj(128'h01_00000004_AABBCCDD_FF, 10), 5'd10, 2'd2,
                mkw(32'h0090_0000, 4'd0, 16'hBBAA, 2'b11),
                mkw(32'h0090_0002, 4'd0, 16'hDDCC, 2'b11), 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{lj(128'h03_00000003_112233, 8), 5'd8, 2'd2,
                mkw(32'h0010_0000, 4'd2, 16'h2211, 2'b11),
                mkw(32'h0010_0002, 4'd2, 16'h0033, 2'b01), 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{lj(128'hF00300, 3), 5'd3, 2'd0, '0, '0, 1'b0, 1'b0, 1'b1, 16'h0300};
    vecs[3] = '{lj(128'h09_0100000002_AABB, 8), 5'd8, 2'd0, '0, '0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{lj(128'h02_00000000_02_00000002_5566, 12), 5'd12, 2'd1,
                mkw(32'h3000_0000, 4'd1, 16'h6655, 2'b11), '0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{lj(128'hF00300_F005A5_FF, 7), 5'd7, 2'd0, '0, '0, 1'b1, 1'b0, 1'b1, 16'h05A5};

    do_reset(1'b1);

    foreach (vecs[v]) begin
      do_reset(1'b0);
      obs.delete(); exp_q.delete();
      if (vecs[v].nwr > 0) exp_q.push_back(vecs[v].w0);
      if (vecs[v].nwr > 1) exp_q.push_back(vecs[v].w1);
      rand_ready = 1'b1;
      for (int i = 0; i < int'(vecs[v].n); i++)
        send_byte(vecs[v].stream[127 - 8*i -: 8], 1);
      wait_idle();
      rand_ready = 1'b0;
      cmp_writes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
      chk($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
      chk($sformatf("vec%0d_cfg", v), {board_cfg_valid, board_cfg}, {vecs[v].exp_cfgv, vecs[v].exp_cfg});
      chk($sformatf("vec%0d_in_ready", v), in_ready, 1);
    end

    // Write held off for 5 cycles; completes on the 6th.
    do_reset(1'b0);
    obs.delete();
    wr_ready = 1'b0;
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34};
    foreach (stim[i]) send_byte(stim[i], 0);
    in_valid = 1'b1; in_data = 8'h09;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", wr_valid, 1);
      chk("stall_req", {wr_addr, wr_storage, wr_data, wr_be},
          {32'h0090_0000, 4'd0, 16'h3412, 2'b11});
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    wr_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("stall_drop", {wr_valid, busy, error}, 0);
    chk("stall_count", obs.size(), 1);

    // Reset while a request is pending discards it.
    stim = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h77};
    @(posedge clk); #1;
    foreach (stim[i]) send_byte(stim[i], 0);
    @(negedge clk);
    chk("pre_rst_valid", {wr_valid, wr_be, wr_data}, {1'b1, 2'b01, 16'h0077});
    obs.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_write", {wr_valid, wr_be, wr_data, busy}, 0);
    @(posedge clk); #1;
    send_byte(8'hFF, 0);
    @(negedge clk);
    chk("rst_mid_write_done", {done, obs.size() == 0}, 2'b11);

    // Randomized streams against the reference model.
    for (int it = 0; it < 40; it++) begin
      int nrec, sel, len;
      stim.delete();
      nrec = $urandom_range(1, 5);
      for (int r = 0; r < nrec; r++) begin
        sel = $urandom_range(0, 19);
        if (sel < 14) begin
          stim.push_back(8'($urandom_range(0, 7)));
          len = $urandom_range(0, 7);
          stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h00);
          stim.push_back(8'(len));
          for (int k = 0; k < len; k++) stim.push_back(8'($urandom));
        end else if (sel < 18) begin
          stim.push_back(8'hF0);
          stim.push_back(8'($urandom)); stim.push_back(8'($urandom));
        end else begin
          stim.push_back(8'($urandom_range(8, 8'hEF)));
          stim.push_back(8'($urandom));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        stim.push_back(8'hFF);
        stim.push_back(8'($urandom)); stim.push_back(8'($urandom));
      end
      run_model();
      do_reset(1'b0);
      obs.delete();
      rand_ready = 1'b1;
      foreach (stim[i]) send_byte(stim[i], 2);
      wait_idle();
      rand_ready = 1'b0;
      cmp_writes("rand");
      chk("rand_done", done, m_done);
      chk("rand_error", error, m_err);
      chk("rand_cfg", {board_cfg_valid, board_cfg}, {m_cfgv, m_cfg});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_load_dispatch.md
Name: rom_load_dispatch

Overview:
- Consumes the HPS ROM-download byte stream and routes payload into the game's load regions.
- Decodes per-region headers and board-config records, packs bytes into 16-bit words and issues write requests to the storage arbiters.
- Storage targets are SDR, DDR and BLOCK; base address and storage type come from the package's LOAD_REGIONS table.
- Sits between the ioctl adapter and the SDR/DDR/BRAM write muxes; drives board_cfg for the rest of the system.

Parameters:
- NUM_REGIONS, 8, number of valid region tags (0..NUM_REGIONS-1), indexing LOAD_REGIONS.
- CFG_TAG, 8'hF0, header byte introducing a 2-byte board_cfg_t record.
- END_TAG, 8'hFF, header byte terminating the download.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- wr_valid  out  1  word write request.
- wr_ready  in  1  storage accepts the request.
- wr_addr  out  32  region base_addr + byte offset (always even).
- wr_storage  out  4  region_storage_t of the target region.
- wr_data  out  16  first byte in [7:0], second byte in [15:8].
- wr_be  out  2  byte enables.
- board_cfg  out  16  latched board_cfg_t.
- board_cfg_valid  out  1  high once a config record has been received.
- busy  out  1  high in any state other than HEADER, DONE or ERROR.
- done  out  1  END_TAG seen (sticky).
- error  out  1  protocol error (sticky).

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: in_ready=0, wr_valid=0, wr_addr/wr_data/wr_be/wr_storage=0, board_cfg=0, board_cfg_valid=0, busy=0, done=0, error=0. State=HEADER, and in_ready rises on the first cycle after reset.
- Stream format: tag byte, then one of:
  - Region tag: 4-byte big-endian length L, then L payload bytes.
  - CFG_TAG: game byte, then unused byte.
  - END_TAG: nothing.
- States: HEADER, LEN (byte counter 0..3), DATA_LO, DATA_HI, WRITE, CFG0, CFG1, DONE, ERROR.
- HEADER:
  - tag < NUM_REGIONS: latch the region, offset=0, go to LEN.
  - CFG_TAG: go to CFG0.
  - END_TAG: go to DONE.
  - Any other value: go to ERROR.
- LEN: shift in 4 bytes MSB-first. After the 4th byte:
  - L==0: go to HEADER.
  - Otherwise: remaining=L, go to DATA_LO.
- DATA_LO: store the byte in the low lane, remaining-=1.
  - remaining now 0: go to WRITE with be=2'b01 and the high lane zeroed.
  - Otherwise: go to DATA_HI.
- DATA_HI: store the byte in the high lane, remaining-=1, be=2'b11, go to WRITE.
- WRITE:
  - wr_valid=1 in the cycle after the completing byte is accepted, so byte-to-request latency is 1 cycle.
  - wr_addr/data/be/storage are held stable while wr_valid=1 and wr_ready=0.
  - in_ready=0 throughout WRITE.
  - On wr_valid & wr_ready: offset+=2, wr_valid drops next cycle; go to DATA_LO if remaining>0, else HEADER.
- wr_addr = base_addr + offset, 32-bit modulo 2^32 (wraps, no error). Offset is a 32-bit counter.
- CFG0/CFG1: latch board_cfg[15:8] then board_cfg[7:0]. board_cfg_valid=1 after CFG1, then go to HEADER. A later CFG record overwrites the config.
- DONE and ERROR are terminal until reset. In both, in_ready=1 (stream drained, bytes discarded) and no writes are issued.
- in_ready=1 in HEADER, LEN, DATA_LO, DATA_HI, CFG0, CFG1.
- in_valid=0 in any state: hold state, no counter change.
- Reset mid-write: wr_valid drops next cycle and the partial word is discarded.

Decomposition:
- Shared package: region_t, region_storage_t, LOAD_REGIONS, board_cfg_t, game_t, plus new constants LOAD_TAG_CFG and LOAD_TAG_END, and the load_state_t enum.
- One natural sub-module: rom_word_packer (byte→16-bit packing with byte enables and the WRITE handshake).
- Header/length decode stays in the top module.

Test Plan:
- Bytes 01, 00 00 00 04, AA BB CC DD, FF:
  - Writes {0x0090_0000, 0xBBAA, be=11, SDR} then {0x0090_0002, 0xDDCC, be=11, SDR}.
  - done=1, error=0.
- Bytes 03, 00 00 00 03, 11 22 33:
  - Writes {0x0010_0000, 0x2211, 11, BLOCK} then {0x0010_0002, 0x0033, be=01, BLOCK}.
  - Returns to HEADER.
- Bytes F0 03 00:
  - board_cfg=0x0300 (game=GAME_THUNDFOX), board_cfg_valid=1, no writes.
- wr_ready held low 5 cycles during a write:
  - wr_valid stays 1, fields unchanged, in_ready=0, no bytes consumed.
  - Completes on the 6th cycle.
- Tag 0x09, then further bytes:
  - error=1 sticky, in_ready=1, no writes.
  - reset clears error and state returns to HEADER.
- Region 02 with L=0, then 00 00 00 00 02:
  - No write for the empty region.
  - Next record targets OBJ_DATA_DDR_BASE with storage=DDR, offset restarts at 0.
